alu_seq: RTL and testbench

Parametrised, registered successor to the single-cycle 32-bit ALU. It keeps the existing 4-bit Func encoding, defines the previously undefined opcodes (SLTU, iterative MUL) and fixes signed SLT to use overflow. It adds registered zero/carry/overflow flags and a valid/ready handshake on both input and output. It sits in the EX stage; the hazard unit stalls on in_ready low.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mul_iter.sv | 54 +++++
 rtl/alu_seq.sv | 161 ++++++++++++++++
 tb/tb_alu_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM encoding and Func field positions for alu_seq
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_XNOR = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    // Func[3] inverts In2 and supplies the carry-in; for MUL it selects the high half
    localparam int FUNC_INV    = 3;
    localparam int FUNC_OP_MSB = 2;
    localparam int FUNC_OP_LSB = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - WIDTH-step unsigned shift-add multiplier
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   hold,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic                   busy,
    output logic                   done,
    output logic [2*WIDTH-1:0]     product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;
    logic               last;

    // The final step's sum is exposed combinationally so the result loads on the same edge
    assign last    = busy && (count == CW'(WIDTH - 1));
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = last && !hold;

    // One partial product per cycle; the final step freezes while the consumer is not ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
        end else if (busy && !(last && hold)) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (last) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with flags, valid/ready handshakes and iterative multiply
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic [3:0]       Func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUout,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    logic [0:0]       state;
    logic             mul_hi;
    logic [2:0]       op;
    logic             inv;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             out_free;
    logic             accept;
    logic             mul_op;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] mul_result;
    logic [WIDTH-1:0] res;
    logic             res_carry;
    logic             res_ovf;
    logic             res_illegal;

    assign op   = Func[FUNC_OP_MSB:FUNC_OP_LSB];
    assign inv  = Func[FUNC_INV];
    assign b    = inv ? ~In2 : In2;
    assign full = {1'b0, In1} + {1'b0, b} + {{WIDTH{1'b0}}, inv};
    assign sum  = full[WIDTH-1:0];
    assign cout = full[WIDTH];
    assign ovf  = (In1[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != In1[WIDTH-1]);

    assign out_free  = !out_valid || out_ready;
    assign in_ready  = rst_n && (state == S_IDLE) && out_free;
    assign accept    = in_valid && in_ready;
    assign mul_op    = MUL_EN && (op == OP_MUL);
    assign mul_start = accept && mul_op;

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (mul_start),
                .hold    (!out_free),
                .a       (In1),
                .b       (In2),
                .busy    (mul_busy),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_busy    = 1'b0;
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    assign mul_result = mul_hi ? mul_product[2*WIDTH-1:WIDTH] : mul_product[WIDTH-1:0];

    // Single-cycle op datapath; logical ops act on the possibly inverted In2
    always_comb begin
        res         = '0;
        res_carry   = 1'b0;
        res_ovf     = 1'b0;
        res_illegal = 1'b0;
        case (op)
            OP_AND:  res = In1 & b;
            OP_OR:   res = In1 | b;
            OP_XOR:  res = In1 ^ b;
            OP_XNOR: res = ~(In1 ^ b);
            OP_ADD: begin
                res       = sum;
                res_carry = cout;
                res_ovf   = ovf;
            end
            OP_SLT: begin
                res       = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
                res_carry = cout;
                res_ovf   = ovf;
            end
            OP_SLTU: begin
                res       = {{(WIDTH-1){1'b0}}, ~cout};
                res_carry = cout;
            end
            default: res_illegal = !MUL_EN;
        endcase
    end

    // Control FSM: sit in S_MUL until the multiplier hands its result to the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            mul_hi <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mul_start) begin
                        state  <= S_MUL;
                        mul_hi <= inv;
                    end
                end
                default: begin
                    if (mul_done) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Output register: a new result beats a simultaneous drain; otherwise hold until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ALUout    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept && !mul_op) begin
            out_valid <= 1'b1;
            ALUout    <= res;
            zero      <= (res == '0);
            carry     <= res_carry;
            overflow  <= res_ovf;
            illegal   <= res_illegal;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            ALUout    <= mul_result;
            zero      <= (mul_result == '0);
            carry     <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq
module tb_alu_seq;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_valid0 = 1'b0;
    logic [W-1:0]  In1 = '0;
    logic [W-1:0]  In2 = '0;
    logic [3:0]    Func = '0;
    logic          out_ready = 1'b1;
    logic          in_ready, out_valid, zero, carry, overflow, illegal;
    logic [W-1:0]  ALUout;
    logic          in_ready0, out_valid0, zero0, carry0, overflow0, illegal0;
    logic [W-1:0]  ALUout0;

    int total = 0;
    int bad = 0;

    alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .In1(In1), .In2(In2), .Func(Func), .out_valid(out_valid), .out_ready(out_ready),
        .ALUout(ALUout), .zero(zero), .carry(carry), .overflow(overflow), .illegal(illegal)
    );

    alu_seq #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .In1(In1), .In2(In2), .Func(Func), .out_valid(out_valid0), .out_ready(1'b1),
        .ALUout(ALUout0), .zero(zero0), .carry(carry0), .overflow(overflow0), .illegal(illegal0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: true-integer arithmetic on the operands
    task automatic model(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] bi,
                         output logic [W-1:0] r, output logic c, output logic o);
        logic [W-1:0] bb;
        logic [63:0]  us;
        longint       ss;
        logic [63:0]  prod;
        bb   = f[3] ? ~bi : bi;
        us   = {32'b0, a} + {32'b0, bb} + {63'b0, f[3]};
        ss   = longint'($signed(a)) + longint'($signed(bb)) + longint'({63'b0, f[3]});
        prod = {32'b0, a} * {32'b0, bi};
        r = '0;
        c = 1'b0;
        o = 1'b0;
        case (f[2:0])
            3'd0: r = a & bb;
            3'd1: r = a | bb;
            3'd2: r = a ^ bb;
            3'd3: r = ~(a ^ bb);
            3'd4: begin r = us[31:0]; c = us[32]; o = (ss > SMAX) || (ss < SMIN); end
            3'd5: begin r = (ss < 0) ? 32'd1 : 32'd0; c = us[32]; o = (ss > SMAX) || (ss < SMIN); end
            3'd6: begin r = us[32] ? 32'd0 : 32'd1; c = us[32]; end
            default: r = f[3] ? prod[63:32] : prod[31:0];
        endcase
    endtask

    task automatic check_out(input string tag, input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] bi);
        logic [W-1:0] r;
        logic c, o;
        model(f, a, bi, r, c, o);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".result"}, 64'(ALUout), 64'(r));
        chk({tag, ".zero"}, 64'(zero), 64'(r == '0));
        chk({tag, ".carry"}, 64'(carry), 64'(c));
        chk({tag, ".overflow"}, 64'(overflow), 64'(o));
        chk({tag, ".illegal"}, 64'(illegal), 64'd0);
    endtask

    // Present an op, wait (bounded) for in_ready, and leave time at 1 ns after the accept edge
    task automatic issue(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] bi);
        int n;
        n = 0;
        Func = f;
        In1 = a;
        In2 = bi;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        chk("issue_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] bi);
        issue(f, a, bi);
        if (f[2:0] == 3'b111) begin
            for (int i = 0; i < W; i++) begin
                chk({tag, ".mul_busy"}, 64'({out_valid, in_ready}), 64'd0);
                step();
            end
        end
        check_out(tag, f, a, bi);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [W-1:0] held;
        logic [3:0]   bf [4];

        // reset state
        step();
        step();
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.result", 64'(ALUout), 64'd0);
        chk("rst.flags", 64'({zero, carry, overflow, illegal}), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        step();

        // directed arithmetic
        run_op("add_ovf", 4'b0100, 32'h7FFF_FFFF, 32'h1);
        chk("add_ovf.const", 64'(ALUout), 64'h8000_0000);
        run_op("sub_zero", 4'b1100, 32'd5, 32'd5);
        chk("sub_zero.const", 64'({zero, carry}), 64'b11);
        run_op("slt", 4'b1101, 32'h8000_0000, 32'h1);
        chk("slt.const", 64'(ALUout), 64'd1);
        run_op("sltu", 4'b1110, 32'h8000_0000, 32'h1);
        chk("sltu.const", 64'(ALUout), 64'd0);

        // multiply, both halves
        run_op("mul_lo", 4'b0111, 32'hFFFF_FFFF, 32'd2);
        chk("mul_lo.const", 64'(ALUout), 64'hFFFF_FFFE);
        run_op("mul_hi", 4'b1111, 32'hFFFF_FFFF, 32'd2);
        chk("mul_hi.const", 64'(ALUout), 64'd1);

        // backpressure: drain, then hold the output
        step();
        out_ready = 1'b0;
        run_op("bp_and", 4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
        held = ALUout;
        chk("bp_and.const", 64'(held), 64'h0000_F000);
        Func = 4'b0100;
        In1 = 32'd1;
        In2 = 32'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp.in_ready", 64'(in_ready), 64'd0);
            step();
            chk("bp.hold", 64'({out_valid, ALUout}), 64'({1'b1, held}));
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check_out("bp_add", 4'b0100, 32'd1, 32'd1);

        // back-to-back issue at one op per cycle
        bf[0] = 4'b0001;
        bf[1] = 4'b1010;
        bf[2] = 4'b0011;
        bf[3] = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            Func = bf[k];
            In1 = pick();
            In2 = pick();
            in_valid = 1'b1;
            chk("b2b.in_ready", 64'(in_ready), 64'd1);
            step();
            check_out("b2b", bf[k], In1, In2);
        end
        in_valid = 1'b0;
        run_op("pre_rst", 4'b0100, 32'd40, 32'd2);

        // reset in the middle of a multiply
        issue(4'b0111, 32'd1234, 32'd5678);
        for (int i = 0; i < 9; i++) step();
        rst_n = 1'b0;
        #1;
        chk("midrst.valid", 64'(out_valid), 64'd0);
        chk("midrst.result", 64'(ALUout), 64'd0);
        chk("midrst.in_ready", 64'(in_ready), 64'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < W + 4; i++) step();
        chk("midrst.no_output", 64'(out_valid), 64'd0);
        run_op("post_rst_add", 4'b0100, 32'd2, 32'd3);
        chk("post_rst_add.const", 64'(ALUout), 64'd5);

        // MUL_EN=0 build: opcode 111 is illegal
        step();
        Func = 4'b0111;
        In1 = 32'hDEAD_BEEF;
        In2 = 32'h3;
        in_valid0 = 1'b1;
        chk("nomul.in_ready", 64'(in_ready0), 64'd1);
        step();
        in_valid0 = 1'b0;
        chk("nomul.out", 64'({out_valid0, illegal0, zero0, carry0, overflow0}), 64'b11100);
        chk("nomul.result", 64'(ALUout0), 64'd0);
        Func = 4'b0100;
        in_valid0 = 1'b1;
        step();
        in_valid0 = 1'b0;
        chk("nomul.add", 64'({illegal0, ALUout0}), 64'({1'b0, 32'hDEAD_BEF2}));

        // randomized ops against the model
        for (int k = 0; k < 40; k++) begin
            logic [3:0] f;
            f = 4'($urandom_range(0, 15));
            run_op("rand", f, pick(), pick());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
